// File: rtl/crater_carver.sv
// crater_carver: read-modify-write engine that cuts circular craters into the terrain column store.
// Define CRATER_SKIP_UNCHANGED_EN to skip write-back of columns the crater leaves untouched.
module crater_carver #(
    parameter int COL_BITS = 512,
    parameter int SCREEN_W = 640,
    parameter int R_MAX    = 31
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [9:0]          req_x,
    input  logic [8:0]          req_y,
    input  logic [4:0]          req_r,
    input  logic                wr_allow,
    output logic                mem_rd_en,
    output logic [9:0]          mem_rd_addr,
    input  logic [COL_BITS-1:0] mem_rd_data,
    output logic                mem_we,
    output logic [9:0]          mem_wr_addr,
    output logic [COL_BITS-1:0] mem_wr_data,
    output logic                busy,
    output logic                done
);
    typedef enum logic [2:0] {IDLE, READ, MODIFY, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [9:0]          x_q, x_d, col_q, col_d, col_hi_q, col_hi_d;
    logic [8:0]          y_q, y_d;
    logic [4:0]          r_q, r_d;
    logic                ready_q, busy_q, done_q, rd_en_q, we_q;
    logic [9:0]          rd_addr_q, wr_addr_q;
    logic [COL_BITS-1:0] wr_data_q, mask, carved;
    logic [10:0]         hi_sum;
    logic [9:0]          lo_c, hi_c, rr, dd, rem, row_hi, row_sum;
    logic [8:0]          row_lo;
    logic [4:0]          dx, h;
    logic                last, skip, advance;

    assign hi_sum = {1'b0, req_x} + {6'd0, req_r};
    assign lo_c   = req_x < {5'd0, req_r} ? 10'd0 : req_x - {5'd0, req_r};
    assign hi_c   = hi_sum > 11'(SCREEN_W - 1) ? 10'(SCREEN_W - 1) : hi_sum[9:0];

    assign dx  = 5'(col_q >= x_q ? col_q - x_q : x_q - col_q);
    assign rr  = {5'd0, r_q} * {5'd0, r_q};
    assign dd  = {5'd0, dx} * {5'd0, dx};
    assign rem = rr - dd;

    // Half-height of the chord: largest h with h*h <= rem, from a parallel compare array.
    always_comb begin
        h = '0;
        for (int i = 1; i <= R_MAX; i++)
            if (10'(i * i) <= rem) h = 5'(i);
    end

    assign row_lo  = y_q < {4'd0, h} ? 9'd0 : y_q - {4'd0, h};
    assign row_sum = {1'b0, y_q} + {5'd0, h};
    assign row_hi  = row_sum > 10'(COL_BITS - 1) ? 10'(COL_BITS - 1) : row_sum;
    assign mask    = ({COL_BITS{1'b1}} << row_lo) & ({COL_BITS{1'b1}} >> (COL_BITS - 1 - int'(row_hi)));
    assign carved  = mem_rd_data & ~mask;
    assign last    = col_q == col_hi_q;

`ifdef CRATER_SKIP_UNCHANGED_EN
    assign skip = (mem_rd_data & mask) == '0;
`else
    assign skip = 1'b0;
`endif

    assign advance = (state_q == MODIFY && skip) || (state_q == WRITE && wr_allow);

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        col_hi_d = col_hi_q;
        x_d      = x_q;
        y_d      = y_q;
        r_d      = r_q;
        case (state_q)
            IDLE: if (req_valid) begin
                x_d      = req_x;
                y_d      = req_y;
                r_d      = req_r;
                col_d    = lo_c;
                col_hi_d = hi_c;
                state_d  = lo_c > hi_c ? DONE : READ;
            end
            READ:    state_d = MODIFY;
            MODIFY:  state_d = skip ? (last ? DONE : READ) : WRITE;
            WRITE:   state_d = wr_allow ? (last ? DONE : READ) : WRITE;
            default: state_d = IDLE;
        endcase
        if (advance && !last) col_d = col_q + 10'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            r_q       <= '0;
            col_q     <= '0;
            col_hi_q  <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            r_q      <= r_d;
            col_q    <= col_d;
            col_hi_q <= col_hi_d;
            ready_q  <= state_d == IDLE;
            busy_q   <= state_d != IDLE;
            done_q   <= state_d == DONE;
            rd_en_q  <= state_d == READ;
            we_q     <= state_d == WRITE;
            if (state_d == READ) rd_addr_q <= col_d;
            if (state_q == MODIFY) begin
                wr_addr_q <= col_q;
                wr_data_q <= carved;
            end
        end
    end

    // The write strobe is gated live by blanking so a held WRITE never fires outside it.
    assign mem_we      = we_q & wr_allow;
    assign req_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
endmodule

// File: tb/tb_crater_carver.sv
// tb_crater_carver: directed bench for crater_carver with a pixel-distance crater model and terrain memory.
module tb_crater_carver;
    localparam int CB = 512;
    localparam int SW = 640;
`ifdef CRATER_SKIP_UNCHANGED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0, reset_n = 1'b0, req_valid = 1'b0, wr_allow = 1'b1;
    logic [9:0]    req_x = '0;
    logic [8:0]    req_y = '0;
    logic [4:0]    req_r = '0;
    logic          req_ready, mem_rd_en, mem_we, busy, done;
    logic [9:0]    mem_rd_addr, mem_wr_addr;
    logic [CB-1:0] mem_rd_data, mem_wr_data;

    logic [CB-1:0] mem [SW];
    logic          fill_en = 1'b0;
    logic [CB-1:0] fill_val = '0;
    int            checks = 0, errors = 0, cyc = 0, wr_count = 0;
    int            t_acc = 0, exp_lat = 0, stall_cycles = 0;
    bit            active = 1'b0;

    typedef struct {
        int            addr;
        logic [CB-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    crater_carver dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_r(req_r), .wr_allow(wr_allow),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [CB-1:0] got, logic [CB-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // A pixel is removed when it lies within Euclidean distance r of the impact point.
    function automatic logic [CB-1:0] carve(int c, int x, int y, int r, logic [CB-1:0] old);
        logic [CB-1:0] w = old;
        for (int n = 0; n < CB; n++)
            if ((c - x) * (c - x) + (n - y) * (n - y) <= r * r) w[n] = 1'b0;
        return w;
    endfunction

    function automatic logic [CB-1:0] hole(int lo, int hi);
        logic [CB-1:0] w = '1;
        for (int n = lo; n <= hi; n++) w[n] = 1'b0;
        return w;
    endfunction

    // Terrain store: one-cycle read latency, write on strobe.
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        if (fill_en) begin
            for (int i = 0; i < SW; i++) mem[i] <= fill_val;
        end else begin
            if (mem_rd_en && mem_rd_addr < 10'(SW)) mem_rd_data <= mem[mem_rd_addr];
            if (mem_we && mem_wr_addr < 10'(SW)) mem[mem_wr_addr] <= mem_wr_data;
        end
    end

    // Compare process: builds the expected write list at acceptance and checks every cycle.
    initial begin
        wr_t           e;
        int            lo, hi, nw, ns;
        logic [CB-1:0] w;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                active = 1'b0;
            end else begin
                chk("rd_we_exclusive", CB'(mem_rd_en & mem_we), '0);
                if (mem_rd_en) chk("rd_addr_range", CB'(mem_rd_addr < 10'(SW)), CB'(1));
                if (req_valid && req_ready) begin
                    lo = int'(req_x) - int'(req_r);
                    hi = int'(req_x) + int'(req_r);
                    if (lo < 0) lo = 0;
                    if (hi > SW - 1) hi = SW - 1;
                    nw = 0;
                    ns = 0;
                    for (int c = lo; c <= hi; c++) begin
                        w = carve(c, int'(req_x), int'(req_y), int'(req_r), mem[c]);
                        if (SKIP && w == mem[c]) ns++;
                        else begin
                            exp_q.push_back('{c, w});
                            nw++;
                        end
                    end
                    exp_lat = 3 * nw + 2 * ns + 1 + stall_cycles;
                    t_acc = cyc;
                    active = 1'b1;
                end
                if (mem_we) begin
                    wr_count++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write got_addr=%0d want=none", mem_wr_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", CB'(mem_wr_addr), CB'(e.addr));
                        chk("wr_data", mem_wr_data, e.data);
                    end
                end
                if (done) begin
                    chk("done_expected", CB'(active), CB'(1));
                    chk("done_latency", CB'(cyc - t_acc), CB'(exp_lat));
                    chk("writes_left", CB'(exp_q.size()), '0);
                    active = 1'b0;
                end
            end
        end
    end

    task automatic fill(logic [CB-1:0] v);
        fill_val = v;
        fill_en = 1'b1;
        @(posedge clk);
        #1 fill_en = 1'b0;
    endtask

    task automatic do_req(int x, int y, int r);
        @(posedge clk);
        #1;
        req_x = 10'(x);
        req_y = 9'(y);
        req_r = 5'(r);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(string name, int lat_lit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 400);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=no_done want=done", name);
        end else chk({name, "_lat"}, CB'(cyc - t_acc), CB'(lat_lit));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_ready"}, CB'(req_ready), CB'(1));
        chk({tag, "_busy"}, CB'(busy), '0);
        chk({tag, "_done"}, CB'(done), '0);
        chk({tag, "_rd_en"}, CB'(mem_rd_en), '0);
        chk({tag, "_we"}, CB'(mem_we), '0);
        chk({tag, "_rd_addr"}, CB'(mem_rd_addr), '0);
        chk({tag, "_wr_addr"}, CB'(mem_wr_addr), '0);
        chk({tag, "_wr_data"}, mem_wr_data, '0);
    endtask

    initial begin
        int w0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset during MODIFY of the third column of a 1..5 crater.
        fill('1);
        do_req(3, 10, 2);
        repeat (7) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("abort");
        @(posedge clk);
        #1 reset_n = 1'b1;
        chk("abort_col1", mem[1], hole(10, 10));
        chk("abort_col2", mem[2], hole(9, 11));
        chk("abort_col3", mem[3], '1);

        fill('1);
        do_req(100, 200, 3);
        wait_done("r3", 22);
        chk("r3_col100", mem[100], hole(197, 203));
        chk("r3_col99", mem[99], hole(198, 202));
        chk("r3_col102", mem[102], hole(198, 202));
        chk("r3_col97", mem[97], hole(200, 200));
        chk("r3_col103", mem[103], hole(200, 200));
        chk("r3_col96", mem[96], '1);
        chk("r3_col104", mem[104], '1);

        fill('1);
        do_req(5, 0, 0);
        wait_done("r0", 4);
        chk("r0_col5", mem[5], hole(0, 0));
        chk("r0_col4", mem[4], '1);

        fill('1);
        do_req(2, 3, 5);
        wait_done("left_edge", 25);
        chk("left_col2", mem[2], hole(0, 8));
        chk("left_col0", mem[0], hole(0, 7));
        chk("left_col8", mem[8], '1);

        fill('1);
        do_req(638, 511, 2);
        wait_done("right_edge", 13);
        chk("right_col639", mem[639], hole(510, 511));
        chk("right_col638", mem[638], hole(509, 511));

        w0 = wr_count;
        do_req(700, 50, 4);
        wait_done("off_screen", 1);
        chk("off_screen_writes", CB'(wr_count - w0), '0);

        // Ten blanking-denied cycles in the first WRITE, plus a request pulse while busy.
        fill('1);
        stall_cycles = 10;
        do_req(300, 100, 1);
        stall_cycles = 0;
        wr_allow = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("stall_we", CB'(mem_we), '0);
                chk("stall_addr", CB'(mem_wr_addr), CB'(299));
                chk("stall_data", mem_wr_data, hole(100, 100));
            end
            if (i == 4) begin
                chk("busy_not_ready", CB'(req_ready), '0);
                #1;
                req_x = 10'd10;
                req_valid = 1'b1;
            end
            if (i == 6) #1 req_valid = 1'b0;
        end
        @(posedge clk);
        #1 wr_allow = 1'b1;
        wait_done("stall", 20);
        chk("stall_col300", mem[300], hole(99, 101));
        chk("stall_col10", mem[10], '1);

        fill('0);
        w0 = wr_count;
        do_req(50, 50, 2);
`ifdef CRATER_SKIP_UNCHANGED_EN
        wait_done("empty", 11);
        chk("empty_writes", CB'(wr_count - w0), '0);
`else
        wait_done("empty", 16);
        chk("empty_writes", CB'(wr_count - w0), CB'(5));
`endif
        chk("empty_col50", mem[50], '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/crater_carver.md
# crater_carver

Read-modify-write engine that cuts circular craters into the terrain column store when a bomb detonates. Sits between the player/bomb logic and the terrain block: accepts an impact request (x, y, radius), then for each affected column reads the 512-bit terrain word, clears solid bits inside the circle, and writes the word back. Writes are issued only during VGA blanking, so the display path never sees a half-updated column.

## Interface
Parameters:
- COL_BITS, 512, bits per terrain column word; bit n = screen row n, 1 = solid
- SCREEN_W, 640, number of valid columns, 0..SCREEN_W-1
- R_MAX, 31, largest accepted radius (req_r width 5)

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  impact request present
- req_ready  out  1  carver can accept a request
- req_x  in  10  impact column
- req_y  in  9  impact row
- req_r  in  5  crater radius in pixels
- wr_allow  in  1  high during blanking; write permitted
- mem_rd_en  out  1  terrain read strobe
- mem_rd_addr  out  10  terrain read column
- mem_rd_data  in  COL_BITS  read data, valid the cycle after mem_rd_en
- mem_we  out  1  terrain write strobe
- mem_wr_addr  out  10  terrain write column
- mem_wr_data  out  COL_BITS  carved column word
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse when a request completes

## Operation
- States: IDLE, READ, MODIFY, WRITE, DONE.
- IDLE: req_ready=1. On req_valid&req_ready latch x, y, r; col_lo=max(0,x-r), col_hi=min(SCREEN_W-1,x+r) (signed 11-bit arithmetic); col=col_lo. If col_lo>col_hi (req_x>=SCREEN_W) go to DONE, else READ.
- READ: mem_rd_en=1, mem_rd_addr=col. Next MODIFY.
- MODIFY: dx=|col-x|; rem=r*r-dx*dx (10-bit, never negative within range); h=largest integer 0..R_MAX with h*h<=rem (combinational compare array). mask bit n=1 for max(0,y-h)<=n<=min(COL_BITS-1,y+h). Register wdata=mem_rd_data & ~mask. Next WRITE.
- WRITE: hold mem_wr_addr=col, mem_wr_data=wdata. mem_we=wr_allow. Stay while wr_allow=0. When written: col==col_hi -> DONE, else col+1 -> READ.
- DONE: done=1 for exactly one cycle, next IDLE.
- req_valid while busy is ignored (not latched); upstream must hold it until req_ready.
- r=0: single column, single pixel at y.

## Timing
- Reset (async assert, sync deassert by top): state IDLE; req_ready=1; busy, done, mem_rd_en, mem_we=0; mem_rd_addr, mem_wr_addr=0; mem_wr_data=0.
- Accept at cycle T; with wr_allow held high, N columns give writes at T+3, T+6, ... T+3N; done at T+3N+1; req_ready at T+3N+2.
- Each low wr_allow cycle in WRITE adds one cycle; no other stalls.
- mem_we is a single-cycle strobe per column; rd and we never asserted in the same cycle.
- Reset mid-request: immediate abort to IDLE; already-written columns stay carved, no done pulse.

## Configuration
- CRATER_SKIP_UNCHANGED_EN defined: in MODIFY, if (mem_rd_data & mask)==0 the column is skipped (no WRITE; go to READ of col+1, or DONE if last), saving blanking bandwidth. Per-column cost becomes 2 cycles for untouched columns.
- Undefined: every column in range is written back, even if unchanged.

## Test plan
- All-solid memory, req x=100 y=200 r=3: writes to cols 97..103; col 100 clears rows 197..203, cols 98/99/101/102 rows 198..202, cols 97/103 row 200 only; done at T+22.
- r=0 at x=5 y=0: one write, col 5 bit 0 cleared, all other bits unchanged; done at T+4.
- Edge clamp x=2 y=3 r=5: cols 0..7 only written; col 2 clears rows 0..8; no access to address >=640 or wrap.
- wr_allow low for 10 cycles during first WRITE: mem_we stays 0, address/data held, completion delayed exactly 10 cycles; req_valid pulsed while busy is not accepted.
- reset_n low in the MODIFY of the 3rd column: outputs return to reset values that cycle, cols 1-2 remain carved, next request accepted normally.
- With CRATER_SKIP_UNCHANGED_EN, crater over all-empty memory r=2: zero mem_we pulses, done at T+11; without macro, 5 writes, done at T+16.
